// File: rtl/inc_stage_pkg.sv
// Shared definitions for the INC output stage: FSM state encoding and width.
package inc_stage_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/inc_stage_entry.sv
// One buffer slot: data register plus optional wrap flag, loaded on enable.
// The wrap flag is only stored when INC_SKID_WRAP_DETECT_EN is defined.
module inc_stage_entry #(
  parameter int DATAWIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATAWIDTH-1:0] data_d,
  input  logic                 wrap_d,
  output logic [DATAWIDTH-1:0] data_q,
  output logic                 wrap_q
);

  logic [DATAWIDTH-1:0] data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= data_d;
    end
  end

  assign data_q = data_reg;

`ifdef INC_SKID_WRAP_DETECT_EN
  logic wrap_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_reg <= 1'b0;
    end else if (load) begin
      wrap_reg <= wrap_d;
    end
  end

  assign wrap_q = wrap_reg;
`else
  logic unused_wrap;
  assign unused_wrap = wrap_d;
  assign wrap_q      = 1'b0;
`endif

endmodule

// File: rtl/inc_skid_stage.sv
// Registered 2-entry valid/ready skid stage after the INC incrementer, with pop counter.
// Optional per-entry wrap flag when INC_SKID_WRAP_DETECT_EN is defined.
module inc_skid_stage
  import inc_stage_pkg::*;
#(
  parameter int DATAWIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_wrap,
  output logic [DATAWIDTH-1:0] xfer_count
);

  state_t               state_reg;
  logic                 in_ready_reg;
  logic                 out_valid_reg;
  logic [DATAWIDTH-1:0] xfer_count_reg;

  logic                 push, pop;
  logic                 main_load, skid_load;
  logic [DATAWIDTH-1:0] main_d, main_q, skid_q;
  logic                 main_wrap_d, main_wrap_q, skid_wrap_q;
  logic                 in_wrap;

  assign push = in_valid & in_ready_reg;
  assign pop  = out_valid_reg & out_ready;

  // INC only yields zero from an all-ones operand, so zero marks a wrap.
  assign in_wrap = (in_data == '0);

  assign main_load = ((state_reg == ST_EMPTY) & push) |
                     ((state_reg == ST_ONE) & push & pop) |
                     ((state_reg == ST_FULL) & pop);
  assign skid_load = (state_reg == ST_ONE) & push & ~pop;

  // Main refills from the skid slot when draining out of FULL.
  assign main_d      = (state_reg == ST_FULL) ? skid_q : in_data;
  assign main_wrap_d = (state_reg == ST_FULL) ? skid_wrap_q : in_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_EMPTY;
      in_ready_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      xfer_count_reg <= '0;
    end else begin
      if (pop) begin
        xfer_count_reg <= xfer_count_reg + 1'b1;
      end
      case (state_reg)
        ST_EMPTY: begin
          in_ready_reg <= 1'b1;
          if (push) begin
            state_reg     <= ST_ONE;
            out_valid_reg <= 1'b1;
          end else begin
            out_valid_reg <= 1'b0;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            state_reg     <= ST_FULL;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b1;
          end else if (!push && pop) begin
            state_reg     <= ST_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
          end else begin
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b1;
          end
        end
        ST_FULL: begin
          out_valid_reg <= 1'b1;
          if (pop) begin
            state_reg    <= ST_ONE;
            in_ready_reg <= 1'b1;
          end else begin
            in_ready_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  inc_stage_entry #(.DATAWIDTH(DATAWIDTH)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .data_d (main_d),
    .wrap_d (main_wrap_d),
    .data_q (main_q),
    .wrap_q (main_wrap_q)
  );

  inc_stage_entry #(.DATAWIDTH(DATAWIDTH)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .data_d (in_data),
    .wrap_d (in_wrap),
    .data_q (skid_q),
    .wrap_q (skid_wrap_q)
  );

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign out_data   = main_q;
  assign out_wrap   = main_wrap_q & out_valid_reg;
  assign xfer_count = xfer_count_reg;

endmodule
